// File: rtl/tbuf_bus_arbiter_if.sv
// Request/grant/enable bundle for the shared tristate bus arbiter.
// master: requesting side; slave: the arbiter itself.
interface tbuf_bus_arbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [N-1:0]  oe;
  logic [OW-1:0] owner;
  logic          busy;

  modport master (output req, input gnt, input oe, input owner, input busy);
  modport slave  (input req, output gnt, output oe, output owner, output busy);
endinterface

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner sequencer for a TBUF-driven shared bus with an all-off turnaround gap.
// Optional per-owner hold limit enabled by defining TBUF_ARB_HOLD_LIMIT_EN.
module tbuf_bus_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned TURN     = 1,
  parameter int unsigned HOLD_MAX = 8
) (
  input logic               clk,
  input logic               r,
  tbuf_bus_arbiter_if.slave bus
);
  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOwn  = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  if (N < 2 || N > 16 || TURN < 1 || TURN > 4 || HOLD_MAX < 1 || HOLD_MAX > 255)
  begin : gen_bad_param
    $error("tbuf_bus_arbiter: parameter out of legal range");
  end

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_q, rr_d;
  logic [2:0]    gap_q, gap_d;
  logic [OW-1:0] pick, idx;
  logic          found;
  logic          release_own;

  // First requester at or above the rr pointer, wrapping past N-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = OW'((32'(rr_q) + k) % N);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef TBUF_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_q, hold_d;
  assign release_own = !bus.req[owner_q] || (hold_q == 8'(HOLD_MAX));
`else
  assign release_own = !bus.req[owner_q];
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
`ifdef TBUF_ARB_HOLD_LIMIT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StOwn;
          gnt_d   = N'(1) << pick;
          owner_d = pick;
`ifdef TBUF_ARB_HOLD_LIMIT_EN
          hold_d  = 8'd1;
`endif
        end
      end
      StOwn: begin
        if (release_own) begin
          // Owner keeps its index through the gap; it drops to lowest priority.
          state_d = StGap;
          gnt_d   = '0;
          rr_d    = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
          gap_d   = 3'(TURN);
        end else begin
`ifdef TBUF_ARB_HOLD_LIMIT_EN
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      StGap: begin
        if (gap_q > 3'd1) begin
          gap_d = gap_q - 3'd1;
        end else if (found) begin
          state_d = StOwn;
          gnt_d   = N'(1) << pick;
          owner_d = pick;
`ifdef TBUF_ARB_HOLD_LIMIT_EN
          hold_d  = 8'd1;
`endif
        end else begin
          state_d = StIdle;
          owner_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
`ifdef TBUF_ARB_HOLD_LIMIT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
`ifdef TBUF_ARB_HOLD_LIMIT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  // OE and GNT share one register so they can never disagree.
  assign bus.gnt   = gnt_q;
  assign bus.oe    = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q != StIdle);
endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Directed and randomized checks for tbuf_bus_arbiter (N=4, TURN=1, HOLD_MAX=8).
module tb_tbuf_bus_arbiter;
  localparam int unsigned N        = 4;
  localparam int unsigned TURN     = 1;
  localparam int unsigned HOLD_MAX = 8;

  logic clk = 1'b0;
  logic r   = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  tbuf_bus_arbiter_if #(.N(N)) bus ();

  tbuf_bus_arbiter #(
    .N       (N),
    .TURN    (TURN),
    .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk(clk),
    .r  (r),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] prev_oe;
    int         off_run;
    bit         seen;
    bus.req = 4'b0000;

    // Reset state
    r = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_oe", 32'(bus.oe), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    r = 1'b1;
    tick();
    chk("idle_gnt", 32'(bus.gnt), 0);

    // Single request on requester 2
    bus.req = 4'b0100;
    tick();
    chk("single_gnt", 32'(bus.gnt), 32'h4);
    chk("single_oe", 32'(bus.oe), 32'h4);
    chk("single_owner", 32'(bus.owner), 2);
    chk("single_busy", 32'(bus.busy), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_hold", 32'(bus.oe), 32'h4);
    end
    bus.req = 4'b0000;
    tick();
    chk("rel_oe", 32'(bus.oe), 0);
    chk("rel_busy", 32'(bus.busy), 1);
    chk("rel_owner", 32'(bus.owner), 2);
    tick();
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_owner", 32'(bus.owner), 0);

    // rr pointer is now 3: owner 3, then wrap to 0 ahead of 3
    bus.req = 4'b1000;
    tick();
    chk("own3_gnt", 32'(bus.gnt), 32'h8);
    chk("own3_owner", 32'(bus.owner), 3);
    bus.req = 4'b0001;
    tick();
    chk("own3_rel", 32'(bus.oe), 0);
    bus.req = 4'b1001;
    tick();
    chk("wrap_gnt", 32'(bus.gnt), 32'h1);
    chk("wrap_owner", 32'(bus.owner), 0);

    // Reset mid-grant
    bus.req = 4'b0001;
    r = 1'b0;
    tick();
    chk("midrst_gnt", 32'(bus.gnt), 0);
    chk("midrst_oe", 32'(bus.oe), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    r = 1'b1;
    tick();
    chk("postrst_gnt", 32'(bus.gnt), 32'h1);

    // Full contention, each owner holds 3 cycles then drops for one edge
    r = 1'b0;
    tick();
    r = 1'b1;
    bus.req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      tick();
      chk("rot_gnt", 32'(bus.gnt), 32'(1 << (o % 4)));
      chk("rot_owner", 32'(bus.owner), 32'(o % 4));
      tick();
      tick();
      chk("rot_hold", 32'(bus.oe), 32'(1 << (o % 4)));
      bus.req[o % 4] = 1'b0;
      tick();
      chk("rot_gap", 32'(bus.oe), 0);
      chk("rot_gap_busy", 32'(bus.busy), 1);
      bus.req[o % 4] = 1'b1;
    end

`ifdef TBUF_ARB_HOLD_LIMIT_EN
    r = 1'b0;
    tick();
    r = 1'b1;
    bus.req = 4'b0011;
    tick();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < int'(HOLD_MAX); i++) begin
        chk("hold_gnt", 32'(bus.gnt), (p % 2 == 0) ? 32'h1 : 32'h2);
        tick();
      end
      chk("hold_gap", 32'(bus.gnt), 0);
      tick();
    end
`endif

    // Random contention monitor
    prev_oe = '0;
    off_run = 0;
    seen    = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      bus.req = 4'($urandom);
      r = ($urandom_range(0, 199) != 0);
      tick();
      chk("mon_oe_gnt", 32'(bus.oe), 32'(bus.gnt));
      chk("mon_onehot", ($countones(bus.oe) <= 1) ? 32'd1 : 32'd0, 1);
      if (!r) begin
        chk("mon_rst", 32'(bus.oe), 0);
        seen    = 1'b0;
        off_run = 0;
      end else if (bus.oe != 4'b0000) begin
        if (prev_oe != 4'b0000) begin
          chk("mon_switch", 32'(bus.oe), 32'(prev_oe));
        end else if (seen) begin
          chk("mon_gap", (off_run >= int'(TURN)) ? 32'd1 : 32'd0, 1);
        end
        seen    = 1'b1;
        off_run = 0;
      end else begin
        off_run++;
      end
      prev_oe = bus.oe;
    end
    r = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
